// File: rtl/add_pkg.sv
// add_pkg: shared definitions for the shared-adder arbiter.
//   W_DEF     default operand/sum width
//   opnd_t    operand pair {a,b} at default width
//   res_t     result {cout,sum,id} at default width
//   next_ptr  round-robin pointer advance with wrap
package add_pkg;

   localparam int W_DEF   = 64;
   localparam int IDW_DEF = 2;

   typedef struct packed {
      logic [W_DEF-1:0] a;
      logic [W_DEF-1:0] b;
   } opnd_t;

   typedef struct packed {
      logic               cout;
      logic [W_DEF-1:0]   sum;
      logic [IDW_DEF-1:0] id;
   } res_t;

   // Pointer after granting idx: one past the winner, wrapping at n.
   function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/add_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    request vector
//   ptr    index with highest priority this cycle
//   en     gate; no grant when low
//   grant  one-hot winner (or zero)
//   gidx   winner index
//   any    a winner exists
// The request vector is doubled so a single lowest-set-bit scan starting
// at ptr naturally wraps past NREQ-1 back to 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  gidx,
   output logic            any
);

   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] masked;

   always_comb begin
      dbl    = {req, req};
      masked = '0;
      // Lower copy only counts from ptr up; upper copy supplies the wrap.
      for (int j = 0; j < 2*NREQ; j++)
         masked[j] = dbl[j] && (j >= int'(ptr));
   end

   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      if (en) begin
         for (int j = 0; j < 2*NREQ; j++) begin
            if (!any && masked[j]) begin
               any = 1'b1;
               if (j >= NREQ) begin
                  gidx             = IDW'(j - NREQ);
                  grant[j - NREQ]  = 1'b1;
               end else begin
                  gidx     = IDW'(j);
                  grant[j] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/add_arb.sv
// add_arb: round-robin scheduler sharing one W-bit adder among NREQ
// requesters, with a single registered result slot.
//   clk, reset            clock, async active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   result slot handshake
//   rsp_sum, rsp_cout     a+b mod 2^W and its carry-out
//   rsp_id                granted requester index
//   op_count              completed result handshakes, wrapping
module add_arb
   import add_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = W_DEF,
   parameter int IDW  = 2,
   parameter int CNTW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_sum,
   output logic              rsp_cout,
   output logic [IDW-1:0]    rsp_id,
   output logic [CNTW-1:0]   op_count
);

   generate
      if (NREQ < 2 || IDW != $clog2(NREQ)) begin : g_bad_param
         $error("add_arb: need NREQ >= 2 and IDW == clog2(NREQ)");
      end
   endgenerate

   typedef struct packed {
      logic           cout;
      logic [W-1:0]   sum;
      logic [IDW-1:0] id;
   } res_w_t;

   logic [NREQ-1:0][W-1:0] a_arr, b_arr;
   logic [NREQ-1:0]        grant;
   logic [IDW-1:0]         gidx;
   logic [IDW-1:0]         ptr;
   logic                   any;
   logic                   accept;
   logic [W:0]             sum_nxt;
   res_w_t                 res_q;

   assign a_arr = req_a;
   assign b_arr = req_b;

   // Slot can take a new result when empty or being drained this cycle.
   assign accept = !rsp_valid || rsp_ready;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (accept && !reset),
      .grant (grant),
      .gidx  (gidx),
      .any   (any)
   );

   assign req_ready = grant;
   assign sum_nxt   = {1'b0, a_arr[gidx]} + {1'b0, b_arr[gidx]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         res_q     <= '0;
         ptr       <= '0;
         op_count  <= '0;
      end else begin
         // A grant implies accept, so a reload also covers the drain case.
         if (any) begin
            rsp_valid <= 1'b1;
            res_q     <= '{cout: sum_nxt[W], sum: sum_nxt[W-1:0], id: gidx};
            ptr       <= IDW'(next_ptr(int'(gidx), NREQ));
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (rsp_valid && rsp_ready)
            op_count <= op_count + 1'b1;
      end
   end

   assign rsp_sum  = res_q.sum;
   assign rsp_cout = res_q.cout;
   assign rsp_id   = res_q.id;

endmodule

// File: tb/tb_add_arb.sv
module tb_add_arb;

   localparam int NREQ = 4;
   localparam int W    = 64;
   localparam int IDW  = 2;
   localparam int CNTW = 32;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0][W-1:0] a_arr, b_arr;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [W-1:0]           rsp_sum;
   logic                   rsp_cout;
   logic [IDW-1:0]         rsp_id;
   logic [CNTW-1:0]        op_count;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   add_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (a_arr),
      .req_b     (b_arr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      a_arr     = '0;
      b_arr     = '0;
      step();
      step();

      // reset state; req_ready gated while reset is high
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_sum",   rsp_sum, 64'd0);
      chk("rst_cout",  64'(rsp_cout), 64'd0);
      chk("rst_id",    64'(rsp_id), 64'd0);
      chk("rst_cnt",   64'(op_count), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);

      // 1: single transfer, 5+7
      reset     = 1'b0;
      req_valid = 4'b0001;
      a_arr[0]  = 64'd5;
      b_arr[0]  = 64'd7;
      rsp_ready = 1'b1;
      #1;
      chk("t1_ready", 64'(req_ready), 64'b0001);
      step();
      chk("t1_valid", 64'(rsp_valid), 64'd1);
      chk("t1_sum",   rsp_sum, 64'd12);
      chk("t1_cout",  64'(rsp_cout), 64'd0);
      chk("t1_id",    64'(rsp_id), 64'd0);
      req_valid = 4'b0000;
      step();
      chk("t1_cnt",   64'(op_count), 64'd1);
      chk("t1_drain", 64'(rsp_valid), 64'd0);

      // 2: overflow on requester 2 (ptr is 1, scan 1 -> 2)
      req_valid = 4'b0100;
      a_arr[2]  = 64'hFFFF_FFFF_FFFF_FFFF;
      b_arr[2]  = 64'd1;
      #1;
      chk("t2_ready", 64'(req_ready), 64'b0100);
      step();
      chk("t2_sum",  rsp_sum, 64'd0);
      chk("t2_cout", 64'(rsp_cout), 64'd1);
      chk("t2_id",   64'(rsp_id), 64'd2);
      req_valid = 4'b0000;
      step();
      chk("t2_cnt",  64'(op_count), 64'd2);

      // reset pulse between edges: ptr and count back to 0
      reset = 1'b1;
      #1;
      chk("rp_cnt", 64'(op_count), 64'd0);
      reset = 1'b0;

      // 3: all valid, rsp_ready=1 -> 0,1,2,3,0,1,2,3 with no bubbles
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = 64'(100 * (i + 1));
         b_arr[i] = 64'(i + 1);
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("t3_valid%0d", k), 64'(rsp_valid), 64'd1);
         chk($sformatf("t3_id%0d", k),    64'(rsp_id), 64'(k % 4));
         chk($sformatf("t3_sum%0d", k),   rsp_sum, 64'(101 * (k % 4 + 1)));
      end
      req_valid = 4'b0000;
      step();
      chk("t3_cnt",   64'(op_count), 64'd8);
      chk("t3_drain", 64'(rsp_valid), 64'd0);

      // 4: backpressure with a pending result from requester 0
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      #1;
      chk("t4_ready0", 64'(req_ready), 64'b0001);
      step();
      req_valid = 4'b0110;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("t4_stall_rdy%0d", k), 64'(req_ready), 64'd0);
         step();
         chk($sformatf("t4_stall_vld%0d", k), 64'(rsp_valid), 64'd1);
         chk($sformatf("t4_stall_id%0d", k),  64'(rsp_id), 64'd0);
         chk($sformatf("t4_stall_sum%0d", k), rsp_sum, 64'd101);
      end
      rsp_ready = 1'b1;
      #1;
      chk("t4_rdy1", 64'(req_ready), 64'b0010);
      step();
      chk("t4_vld1", 64'(rsp_valid), 64'd1);
      chk("t4_id1",  64'(rsp_id), 64'd1);
      chk("t4_sum1", rsp_sum, 64'd202);
      chk("t4_cnt1", 64'(op_count), 64'd9);
      chk("t4_rdy2", 64'(req_ready), 64'b0100);
      step();
      chk("t4_vld2", 64'(rsp_valid), 64'd1);
      chk("t4_id2",  64'(rsp_id), 64'd2);
      chk("t4_sum2", rsp_sum, 64'd303);
      req_valid = 4'b0000;
      step();
      chk("t4_cnt",  64'(op_count), 64'd11);

      // 5: priority hold. ptr=3; requester 1 wins -> ptr=2
      req_valid = 4'b0010;
      #1;
      chk("t5_rdy_a", 64'(req_ready), 64'b0010);
      step();
      req_valid = 4'b0000;
      step();
      step();
      req_valid = 4'b0001;
      #1;
      chk("t5_rdy_b", 64'(req_ready), 64'b0001);
      step();
      chk("t5_id_b", 64'(rsp_id), 64'd0);
      req_valid = 4'b0000;
      step();
      step();
      // ptr should still be 1: scan 1,2,3 finds requester 3 before 0
      req_valid = 4'b1001;
      #1;
      chk("t5_rdy_c", 64'(req_ready), 64'b1000);
      step();
      chk("t5_id_c", 64'(rsp_id), 64'd3);
      req_valid = 4'b0000;
      step();
      chk("t5_cnt",  64'(op_count), 64'd14);

      // 6: reset during a stall
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      step();
      chk("t6_vld_pre", 64'(rsp_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_vld",  64'(rsp_valid), 64'd0);
      chk("t6_cnt",  64'(op_count), 64'd0);
      chk("t6_sum",  rsp_sum, 64'd0);
      chk("t6_rdy",  64'(req_ready), 64'd0);
      #1;
      reset     = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      chk("t6_rdy_post", 64'(req_ready), 64'b0001);
      step();
      chk("t6_id_post",  64'(rsp_id), 64'd0);
      chk("t6_vld_post", 64'(rsp_valid), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/add_arb.md
Name: add_arb

Overview:
- Round-robin arbiter/scheduler that shares one W-bit adder among NREQ requesters.
- Each requester presents an operand pair with valid/ready.
- The block grants one requester per cycle, registers the sum with carry-out and the requester ID into a single output slot, and holds it under backpressure.
- Sits between the add-tree leaf producers and the accumulation stage, replacing per-requester adders.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 64, operand and sum width.
- IDW, 2, requester ID width (must equal clog2(NREQ)).
- CNTW, 32, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing.
- rsp_valid  out  1  result slot occupied.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  a+b mod 2^W.
- rsp_cout  out  1  carry-out of a+b.
- rsp_id  out  IDW  index of the granted requester.
- op_count  out  CNTW  number of completed result handshakes; wraps.

Behaviour:
- Reset (async, active-high): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, op_count=0, round-robin pointer ptr=0. req_ready is combinational and reads 0 while reset is asserted.
- accept = !rsp_valid || rsp_ready. The output slot is free, or is being drained this cycle.
- Grant: when accept=1 and |req_valid, grant the first i with req_valid[i]=1, scanning from ptr upward and wrapping mod NREQ. req_ready = grant (one-hot). If accept=0 or there are no valid requests, req_ready=0.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- Transfer on requester i: req_valid[i] && req_ready[i]. On the next edge: {rsp_cout,rsp_sum} <= req_a[i] + req_b[i] (W+1-bit add), rsp_id <= i, rsp_valid <= 1, ptr <= (i+1) mod NREQ.
- Latency: exactly 1 cycle from transfer to rsp_valid.
- Throughput: 1 result/cycle while rsp_ready=1.
- Drain without refill: rsp_valid && rsp_ready with no transfer in the same cycle gives rsp_valid <= 0.
- Simultaneous drain and grant: the slot is reloaded in the same edge, so rsp_valid stays 1 and there is no bubble.
- Stall: rsp_valid=1 and rsp_ready=0 means rsp_* hold stable and all req_ready=0. ptr holds.
- ptr advances only on a transfer. If there is no grant, ptr holds, so a requester that is not granted keeps its priority.
- op_count increments by 1 on each rsp_valid && rsp_ready and wraps from 2^CNTW-1 to 0.
- Overflow: the sum wraps mod 2^W and rsp_cout captures bit W. No saturation.
- Reset mid-operation: a pending result is discarded and ptr returns to 0. Requesters must re-present their operands.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, the grant order is 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 grants.
- Parameter check: elaboration-time error if IDW != clog2(NREQ) or NREQ<2.

Decomposition:
- Shared package add_pkg:
  - W default constant;
  - the operand-pair struct {a,b};
  - the result struct {cout,sum,id};
  - a function that computes the wrapped next pointer.
- Natural sub-module rr_pick:
  - purely combinational;
  - inputs req[NREQ] and ptr[IDW], an enable;
  - outputs onehot grant[NREQ], gidx[IDW], any.
  - Implemented as a double-width mask-and-priority scan.
- The adder, output slot, ptr and counter stay in add_arb.

Test Plan:
1. Reset, then req_valid=0001, a0=5, b0=7, rsp_ready=1 -> req_ready=0001 in the same cycle. Next cycle: rsp_valid=1, rsp_sum=12, rsp_cout=0, rsp_id=0. One cycle later op_count=1.
2. Overflow: a=0xFFFF_FFFF_FFFF_FFFF, b=1 on requester 2 -> rsp_sum=0, rsp_cout=1, rsp_id=2.
3. Round-robin: req_valid=1111 held for 8 cycles with rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3, one per cycle with no bubbles. op_count=8 after the last handshake.
4. Backpressure: a result is pending and rsp_ready=0 for 3 cycles with req_valid=0110 -> req_ready=0000 and rsp_* stable. Raise rsp_ready -> the same-cycle drain and grant gives requester 1, then requester 2, with rsp_valid continuously 1.
5. Priority hold: ptr=2 with only req_valid=0001 -> requester 0 is granted. The next grant scan starts at 1, and ptr does not move in cycles with no valid requests.
6. Reset mid-stall: rsp_valid=1, rsp_ready=0, assert reset asynchronously between edges -> rsp_valid=0 and op_count=0 immediately. After release, a req_valid=1111 grant goes to requester 0.
